// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared types and limits for the data_sync CDC receive stage
package data_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DATA_SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/data_sync_if.sv
// rtl/data_sync_if.sv - source/consumer bus of data_sync; master drives requests, slave is the sync stage
interface data_sync_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] DataSync_ASYNC_DATA;
  logic             DataSync_ASYNC_REQ;
  logic             DataSync_READY;
  logic             DataSync_CLR_OVR;
  logic [WIDTH-1:0] DataSync_SYNC_DATA;
  logic             DataSync_VALID;
  logic             DataSync_ACK;
  logic             DataSync_OVERRUN;

  modport master (
    output DataSync_ASYNC_DATA,
    output DataSync_ASYNC_REQ,
    output DataSync_READY,
    output DataSync_CLR_OVR,
    input  DataSync_SYNC_DATA,
    input  DataSync_VALID,
    input  DataSync_ACK,
    input  DataSync_OVERRUN
  );

  modport slave (
    input  DataSync_ASYNC_DATA,
    input  DataSync_ASYNC_REQ,
    input  DataSync_READY,
    input  DataSync_CLR_OVR,
    output DataSync_SYNC_DATA,
    output DataSync_VALID,
    output DataSync_ACK,
    output DataSync_OVERRUN
  );

endinterface

// File: rtl/data_sync_toggle_sync.sv
// rtl/data_sync_toggle_sync.sv - STAGES-deep flop chain bringing the request toggle into the local clock
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic BitSync_CLK,
  input  logic BitSync_RST,
  input  logic async_req,
  output logic sync_req
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge BitSync_CLK) begin
    if (BitSync_RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_req};
    end
  end

  assign sync_req = chain[STAGES-1];

endmodule

// File: rtl/data_sync.sv
// rtl/data_sync.sv - captures a toggle-requested bus from another domain and offers it with valid/ready
module data_sync
  import data_sync_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic       DataSync_CLK,
  input  logic       DataSync_RST,
  data_sync_if.slave bus
);

  if (STAGES < DATA_SYNC_MIN_STAGES) begin : g_stages_guard
    $error("data_sync: STAGES must be at least DATA_SYNC_MIN_STAGES");
  end

  logic             sync_req;
  logic             req_q;
  logic             evt;
  logic             accept;
  logic             ack;
  logic             overrun;
  logic [WIDTH-1:0] sync_data;
  state_t           state;

  toggle_sync #(.STAGES(STAGES)) u_toggle_sync (
    .BitSync_CLK (DataSync_CLK),
    .BitSync_RST (DataSync_RST),
    .async_req   (bus.DataSync_ASYNC_REQ),
    .sync_req    (sync_req)
  );

  assign evt    = sync_req ^ req_q;
  assign accept = (state == HOLD) & bus.DataSync_READY;

  always_ff @(posedge DataSync_CLK) begin
    if (DataSync_RST) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      ack       <= 1'b0;
      overrun   <= 1'b0;
      sync_data <= '0;
    end else begin
      // req_q always follows the sync level so a dropped toggle is absorbed by the next ACK
      if (evt) req_q <= sync_req;
      if (bus.DataSync_CLR_OVR) overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (evt) begin
            sync_data <= bus.DataSync_ASYNC_DATA;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            ack <= req_q;
            if (evt) sync_data <= bus.DataSync_ASYNC_DATA;
            else     state     <= IDLE;
          end else if (evt) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.DataSync_SYNC_DATA = sync_data;
  assign bus.DataSync_VALID     = (state == HOLD);
  assign bus.DataSync_ACK       = ack;
  assign bus.DataSync_OVERRUN   = overrun;

endmodule

// File: doc/data_sync.md
# data_sync

Receiving-side clock-domain-crossing stage for multi-bit buses. A source in another clock domain presents a stable bus and flips a request toggle. This block synchronizes the toggle, captures the bus once, and presents it to the local consumer with a valid/ready handshake. It returns an acknowledge toggle level that the source's own synchronizer samples, and flags protocol overruns.

## Interface
- STAGES, 2, synchronizer depth for the request toggle; legal range ≥2
- WIDTH, 8, bus width in bits
- DataSync_CLK  in  1  destination-domain clock
- DataSync_RST  in  1  reset, synchronous, active-high
- DataSync_ASYNC_DATA  in  WIDTH  source bus; held stable by the source from its REQ toggle until it sees ACK match
- DataSync_ASYNC_REQ  in  1  source request toggle, asynchronous to DataSync_CLK
- DataSync_READY  in  1  consumer ready
- DataSync_CLR_OVR  in  1  clears the OVERRUN flag
- DataSync_SYNC_DATA  out  WIDTH  captured bus, registered
- DataSync_VALID  out  1  captured bus available
- DataSync_ACK  out  1  acknowledge toggle level, registered, returned to the source domain
- DataSync_OVERRUN  out  1  sticky protocol-violation flag

## Operation
- Request path: DataSync_ASYNC_REQ passes through an STAGES-flop chain; the last stage is sync_req.
- Consumed level: req_q holds the last consumed level.
- Event: event = sync_req ^ req_q. On every event cycle, req_q <= sync_req.
- FSM has two states, IDLE and HOLD. DataSync_VALID is 1 exactly when the FSM is in HOLD.
- IDLE:
  - On event: SYNC_DATA <= ASYNC_DATA, then go to HOLD.
  - Otherwise: stay in IDLE with no change.
- HOLD, accept = VALID & READY:
  - accept and no event: ACK <= req_q, then go to IDLE. SYNC_DATA holds its value.
  - accept and event: SYNC_DATA <= ASYNC_DATA, ACK <= req_q (the pre-update level), stay in HOLD. OVERRUN is not set.
  - no accept and event: the event is dropped and OVERRUN <= 1. SYNC_DATA is not overwritten. req_q still updates, so the next ACK absorbs the dropped toggle and the source cannot deadlock.
  - no accept and no event: hold all state.
- ACK only ever takes the value of req_q and never toggles on its own.
- OVERRUN:
  - Set by a dropped event.
  - Cleared by CLR_OVR.
  - If set and clear occur in the same cycle, set wins.
- Reset, applied at any time including mid-transfer:
  - Sync chain, req_q, ACK, SYNC_DATA, VALID and OVERRUN all go to 0; state goes to IDLE.
  - Any pending transfer is discarded. The source domain must be reset with it.
- SYNC_DATA is never driven combinationally from ASYNC_DATA.

## Timing
- REQ toggle to VALID high: STAGES+1 rising edges. STAGES edges fill the chain, and the event is registered on the next edge.
- SYNC_DATA is valid in the same cycle VALID rises and stays stable while VALID=1 and READY=0.
- Accept to VALID low and ACK update: both at the same edge where VALID&READY is sampled high.
- Back-to-back throughput: one transfer per accept when the next event coincides with the accept. Otherwise, at most one transfer per STAGES+1 cycles after the source sees ACK.
- First cycle after reset release: all outputs are 0. An event is possible no earlier than STAGES cycles after release.
- REQ held constant: no events. A level of 1 present at reset release produces exactly one event.

## Structure
- Package data_sync_pkg holds:
  - the state encoding (IDLE=1'b0, HOLD=1'b1)
  - the constant DATA_SYNC_MIN_STAGES=2, checked by an elaboration-time guard on STAGES
- One sub-module, toggle_sync:
  - 1-bit, STAGES-deep flop chain with synchronous active-high reset
  - outputs sync_req only
  - event detection and req_q stay in data_sync

## Test plan
- Reset, STAGES=2, WIDTH=8: after RST high for 2 cycles, all outputs are 0. Then toggle REQ 0→1 with DATA=8'hA5 → VALID=1 and SYNC_DATA=8'hA5 exactly 3 edges later; with READY=1 on that cycle, VALID=0 and ACK=1 on the next edge.
- Backpressure: READY=0 for 10 cycles after VALID rises → SYNC_DATA stays 8'hA5 and VALID stays 1. Raising READY gives a single accept and ACK=1.
- Overrun: while in HOLD with READY=0, toggle REQ 1→0 with DATA=8'h3C → OVERRUN=1 and SYNC_DATA stays 8'hA5. On accept, ACK=0, matching REQ. A cycle with CLR_OVR=1 clears OVERRUN; CLR_OVR=1 together with a new overrun leaves OVERRUN=1.
- Simultaneous accept and event: time a toggle so the event lands on the accept cycle with DATA=8'h77 → VALID stays 1, SYNC_DATA=8'h77, OVERRUN=0.
- Reset mid-transfer: assert RST on a HOLD cycle → next edge VALID=0, ACK=0, OVERRUN=0, state IDLE. With REQ=1 still applied, exactly one event is produced after release.
- STAGES=4, WIDTH=16: REQ toggle with DATA=16'hBEEF → VALID rises exactly 5 edges later with SYNC_DATA=16'hBEEF.
